// File: rtl/bt_stream_packetizer_if.sv
// Capture, UART rx/tx and status signals of the Bluetooth telemetry packetizer.
// master = packetizer side, slave = surrounding capture/UART side.
interface bt_stream_packetizer_if #(
    parameter int NCH      = 8,
    parameter int SAMPLE_W = 16
);
    logic                    sample_valid;
    logic [NCH*SAMPLE_W-1:0] raw_bus;
    logic [NCH*SAMPLE_W-1:0] rms_bus;
    logic                    rx_valid;
    logic [7:0]              rx_data;
    logic                    tx_ready;
    logic                    tx_done;
    logic                    tx_en;
    logic [7:0]              tx_data;
    logic                    busy;
    logic                    overrun;
    logic [2:0]              mode;
    logic                    streaming;

    modport master (
        input  sample_valid, raw_bus, rms_bus, rx_valid, rx_data, tx_ready, tx_done,
        output tx_en, tx_data, busy, overrun, mode, streaming
    );
    modport slave (
        output sample_valid, raw_bus, rms_bus, rx_valid, rx_data, tx_ready, tx_done,
        input  tx_en, tx_data, busy, overrun, mode, streaming
    );
endinterface

// File: rtl/bt_stream_packetizer.sv
// Framed telemetry packetizer: SYNC byte + one byte per channel to a UART tx.
// Optional trailing XOR checksum byte when PKT_CHECKSUM_EN is defined.
module bt_stream_packetizer #(
    parameter int         NCH       = 8,
    parameter int         SAMPLE_W  = 16,
    parameter int         CNT_W     = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                  CLK,
    input  logic                  Rst_n,
    bt_stream_packetizer_if.master bus
);
    localparam int IDX_W = $clog2(NCH + 2);
    localparam logic [CNT_W-1:0] P_8192  = CNT_W'(8192);
    localparam logic [CNT_W-1:0] P_16384 = CNT_W'(16384);
    localparam logic [CNT_W-1:0] P_512   = CNT_W'(512);
    localparam logic [CNT_W-1:0] P_256   = CNT_W'(256);

`ifdef PKT_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, CSUM_ISSUE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT} state_t;
`endif

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    period_q, frame_cnt;
    logic [NCH-1:0][7:0] lane_byte, shadow;
    logic [7:0]          tx_byte, tx_data_q;
    logic [2:0]          mode_q;
    logic                tx_en_q, busy_q, overrun_q, streaming_q;
    logic                tick, period_cmd;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        bt_ch_slice #(.SAMPLE_W(SAMPLE_W), .LANE(k)) u_slice (
            .raw   (bus.raw_bus[k*SAMPLE_W +: SAMPLE_W]),
            .rms   (bus.rms_bus[k*SAMPLE_W +: SAMPLE_W]),
            .mode  (mode_q),
            .slice (lane_byte[k])
        );
    end

    // Tick is judged against the registers as they stand before this edge.
    assign tick       = bus.sample_valid && (frame_cnt == period_q - CNT_W'(1));
    assign period_cmd = bus.rx_valid && (bus.rx_data == 8'd2 || bus.rx_data == 8'd3 ||
                                         bus.rx_data == 8'd9 || bus.rx_data == 8'd10);

    // idx 0 is SYNC, idx k+1 is channel k.
    always_comb begin
        tx_byte = SYNC_BYTE;
        for (int k = 0; k < NCH; k++)
            if (idx == IDX_W'(k + 1)) tx_byte = shadow[k];
    end

`ifdef PKT_CHECKSUM_EN
    logic [7:0] csum_next, csum_q;
    always_comb begin
        csum_next = SYNC_BYTE;
        for (int k = 0; k < NCH; k++) csum_next = csum_next ^ lane_byte[k];
    end

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n)                                 csum_q <= '0;
        else if (state == IDLE && tick && streaming_q) csum_q <= csum_next;
    end
`endif

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            period_q    <= P_8192;
            frame_cnt   <= '0;
            shadow      <= '0;
            tx_data_q   <= 8'h00;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            mode_q      <= 3'd3;
            streaming_q <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;

            if (bus.rx_valid) begin
                case (bus.rx_data)
                    8'd0:  streaming_q <= 1'b0;
                    8'd1:  begin streaming_q <= 1'b1; overrun_q <= 1'b0; end
                    8'd2:  period_q <= P_8192;
                    8'd3:  period_q <= P_16384;
                    8'd9:  period_q <= P_512;
                    8'd10: period_q <= P_256;
                    8'd4:  mode_q <= 3'd0;
                    8'd5:  mode_q <= 3'd1;
                    8'd6:  mode_q <= 3'd2;
                    8'd7:  mode_q <= 3'd3;
                    8'd8:  mode_q <= 3'd4;
                    default: ;
                endcase
            end

            if (period_cmd || tick)     frame_cnt <= '0;
            else if (bus.sample_valid)  frame_cnt <= frame_cnt + CNT_W'(1);

            // A tick while a packet is in flight is dropped; overrun wins over a same-edge clear.
            if (tick && streaming_q && state != IDLE) overrun_q <= 1'b1;

            case (state)
                IDLE: if (tick && streaming_q) begin
                    shadow <= lane_byte;
                    busy_q <= 1'b1;
                    state  <= LOAD;
                end
                LOAD: begin
                    idx   <= '0;
                    state <= ISSUE;
                end
                ISSUE: if (bus.tx_ready) begin
                    tx_en_q   <= 1'b1;
                    tx_data_q <= tx_byte;
                    state     <= WAIT;
                end
                WAIT: if (bus.tx_done) begin
`ifdef PKT_CHECKSUM_EN
                    if (idx == IDX_W'(NCH + 1)) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (idx == IDX_W'(NCH)) begin
                        state <= CSUM_ISSUE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= ISSUE;
                    end
`else
                    if (idx == IDX_W'(NCH)) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= ISSUE;
                    end
`endif
                end
`ifdef PKT_CHECKSUM_EN
                CSUM_ISSUE: if (bus.tx_ready) begin
                    tx_en_q   <= 1'b1;
                    tx_data_q <= csum_q;
                    idx       <= IDX_W'(NCH + 1);
                    state     <= WAIT;
                end
`endif
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_en     = tx_en_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
    assign bus.mode      = mode_q;
    assign bus.streaming = streaming_q;
endmodule

// Per-channel byte selector; unknown mode encodings behave as DEBUG.
module bt_ch_slice #(
    parameter int SAMPLE_W = 16,
    parameter int LANE     = 0
) (
    input  logic [SAMPLE_W-1:0] raw,
    input  logic [SAMPLE_W-1:0] rms,
    input  logic [2:0]          mode,
    output logic [7:0]          slice
);
    localparam logic [7:0] LANE_ID = 8'(LANE);

    logic lane_unused;
    assign lane_unused = ^{raw, rms};

    always_comb begin
        case (mode)
            3'd0:    slice = {raw[SAMPLE_W-1], raw[12:6]};
            3'd1:    slice = {raw[SAMPLE_W-1], raw[10:4]};
            3'd2:    slice = rms[13:6];
            3'd3:    slice = rms[11:4];
            default: slice = LANE_ID;
        endcase
    end
endmodule

// File: tb/tb_bt_stream_packetizer.sv
// Self-checking bench for bt_stream_packetizer: byte-slicing table plus
// multi-cycle sequences (overrun, stop mid-packet, tx_ready stall, async reset).
module tb_bt_stream_packetizer;
    localparam int         NCH  = 8;
    localparam int         SW   = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic CLK = 1'b0;
    logic Rst_n = 1'b0;
    always #5 CLK = ~CLK;

    bt_stream_packetizer_if #(.NCH(NCH), .SAMPLE_W(SW)) bus ();

    bt_stream_packetizer #(.NCH(NCH), .SAMPLE_W(SW), .CNT_W(16), .SYNC_BYTE(SYNC)) dut (
        .CLK   (CLK),
        .Rst_n (Rst_n),
        .bus   (bus.master)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] raw;
        logic [15:0] rms;
        logic        dbg;
        logic [7:0]  exp;
    } vec_t;

    int         nvec = 0, nerr = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_tx = 8'h00, mon_exp;
    int         tx_cnt = 0, done_cnt = 0;
    int         done_dly = 20;
    int         sv_gap = 32;
    bit         sv_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every tx_en pops one expected byte.
    always @(negedge CLK) begin
        if (Rst_n && bus.tx_en) begin
            tx_cnt++;
            last_tx = bus.tx_data;
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_tx_en: got byte %0h, expected no transmission", bus.tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.tx_data !== mon_exp) begin
                    nerr++;
                    $display("FAIL tx_byte: got %0h, expected %0h", bus.tx_data, mon_exp);
                end
            end
        end
        if (Rst_n && bus.tx_done) chk("tx_data_stable", bus.tx_data, last_tx);
    end

    // UART model: tx_done pulses done_dly cycles after each tx_en.
    initial begin
        int cd;
        cd = 0;
        bus.tx_done = 1'b0;
        forever begin
            @(posedge CLK); #1;
            bus.tx_done = 1'b0;
            if (!Rst_n) cd = 0;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) begin bus.tx_done = 1'b1; done_cnt++; end
            end else if (bus.tx_en) cd = done_dly;
        end
    end

    // Frame strobe generator.
    initial begin
        int g;
        g = 0;
        bus.sample_valid = 1'b0;
        forever begin
            @(posedge CLK); #1;
            bus.sample_valid = 1'b0;
            if (sv_en) begin
                g++;
                if (g >= sv_gap) begin bus.sample_valid = 1'b1; g = 0; end
            end
        end
    end

    task automatic send_cmd(input logic [7:0] b);
        @(posedge CLK); #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge CLK); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic push_pkt(input logic dbg, input logic [7:0] val);
        logic [7:0] b, cs;
        exp_q.push_back(SYNC);
        cs = SYNC;
        for (int k = 0; k < NCH; k++) begin
            b = dbg ? 8'(k) : val;
            exp_q.push_back(b);
            cs = cs ^ b;
        end
`ifdef PKT_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic wait_sig(input int which, input logic lvl, input int bound,
                            input string name, output int cyc);
        logic v;
        cyc = 0;
        forever begin
            @(negedge CLK);
            v = (which == 0) ? bus.busy : bus.overrun;
            if (v === lvl || cyc > bound) break;
            cyc++;
        end
        chk(name, 32'(cyc > bound), 32'd0);
    endtask

    task automatic set_buses(input logic [15:0] raw, input logic [15:0] rms);
        for (int k = 0; k < NCH; k++) begin
            bus.raw_bus[k*SW +: SW] = raw;
            bus.rms_bus[k*SW +: SW] = rms;
        end
    endtask

    vec_t tbl[9];

    initial begin
        int c, t0, d0;
        tbl[0] = '{8'd4, 16'h8FC0, 16'h0000, 1'b0, 8'hBF};
        tbl[1] = '{8'd5, 16'h8FC0, 16'h0000, 1'b0, 8'hFC};
        tbl[2] = '{8'd6, 16'h0000, 16'h0AB0, 1'b0, 8'h2A};
        tbl[3] = '{8'd7, 16'h0000, 16'h0AB0, 1'b0, 8'hAB};
        tbl[4] = '{8'd5, 16'h1234, 16'h0000, 1'b0, 8'h23};
        tbl[5] = '{8'd4, 16'h7FFF, 16'h0000, 1'b0, 8'h7F};
        tbl[6] = '{8'd6, 16'h0000, 16'hFFFF, 1'b0, 8'hFF};
        tbl[7] = '{8'd7, 16'h0000, 16'h1234, 1'b0, 8'h23};
        tbl[8] = '{8'd8, 16'h5555, 16'hAAAA, 1'b1, 8'h00};

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        set_buses(16'h0000, 16'h0000);

        repeat (2) @(negedge CLK);
        chk("rst_tx_en", bus.tx_en, 0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_mode", bus.mode, 3'd3);
        chk("rst_streaming", bus.streaming, 0);
        @(posedge CLK); #1 Rst_n = 1'b1;
        sv_en = 1'b1;

        // Debug packet at period 256 with a frame every 32 cycles.
        send_cmd(8'd10);
        send_cmd(8'd8);
        chk("mode_debug", bus.mode, 3'd4);
        push_pkt(1'b1, 8'h00);
        send_cmd(8'd1);
        chk("streaming_on", bus.streaming, 1);
        wait_sig(0, 1'b1, 9000, "first_pkt_start", c);
        send_cmd(8'd0);
        wait_sig(0, 1'b0, 2000, "first_pkt_end", c);
        chk("first_pkt_complete", exp_q.size(), 0);

        // Byte-slicing table, one packet per vector.
        sv_gap = 1;
        foreach (tbl[i]) begin
            set_buses(tbl[i].raw, tbl[i].rms);
            send_cmd(tbl[i].cmd);
            chk("tbl_mode", bus.mode, 3'(tbl[i].cmd - 8'd4));
            push_pkt(tbl[i].dbg, tbl[i].exp);
            send_cmd(8'd1);
            wait_sig(0, 1'b1, 400, "tbl_pkt_start", c);
            send_cmd(8'd0);
            wait_sig(0, 1'b0, 600, "tbl_pkt_end", c);
            chk("tbl_pkt_complete", exp_q.size(), 0);
        end

        // tx_ready held low after the packet starts.
        send_cmd(8'd8);
        bus.tx_ready = 1'b0;
        push_pkt(1'b1, 8'h00);
        send_cmd(8'd1);
        wait_sig(0, 1'b1, 400, "stall_pkt_start", c);
        t0 = tx_cnt;
        repeat (50) @(negedge CLK);
        chk("stall_no_tx_en", tx_cnt, t0);
        bus.tx_ready = 1'b1;
        repeat (4) @(negedge CLK);
        chk("stall_one_tx_en", tx_cnt, t0 + 1);
        send_cmd(8'd0);
        wait_sig(0, 1'b0, 600, "stall_pkt_end", c);
        chk("stall_pkt_complete", exp_q.size(), 0);

        // Stop streaming after the third byte: packet finishes, nothing follows.
        push_pkt(1'b1, 8'h00);
        send_cmd(8'd1);
        wait_sig(0, 1'b1, 400, "stop_pkt_start", c);
        d0 = done_cnt;
        c = 0;
        while (done_cnt < d0 + 3 && c < 300) begin @(negedge CLK); c++; end
        chk("stop_third_done_timeout", 32'(c >= 300), 0);
        send_cmd(8'd0);
        chk("stop_streaming_off", bus.streaming, 0);
        wait_sig(0, 1'b0, 600, "stop_pkt_end", c);
        chk("stop_pkt_complete", exp_q.size(), 0);
        t0 = tx_cnt;
        repeat (600) @(negedge CLK);
        chk("stop_no_more_tx_en", tx_cnt, t0);

        // Slow UART: ticks during the packet set overrun without corrupting it.
        done_dly = 400;
        push_pkt(1'b1, 8'h00);
        send_cmd(8'd1);
        wait_sig(0, 1'b1, 400, "ovr_pkt_start", c);
        wait_sig(1, 1'b1, 1000, "ovr_set", c);
        chk("ovr_busy_in_flight", bus.busy, 1);
        send_cmd(8'd0);
        wait_sig(0, 1'b0, 5000, "ovr_pkt_end", c);
        chk("ovr_pkt_complete", exp_q.size(), 0);
        chk("ovr_sticky", bus.overrun, 1);
        done_dly = 20;
        sv_en = 1'b0;
        repeat (2) @(negedge CLK);
        send_cmd(8'd1);
        chk("ovr_cleared", bus.overrun, 0);
        send_cmd(8'd0);
        sv_en = 1'b1;

        // Asynchronous reset between tx_en and tx_done.
        push_pkt(1'b1, 8'h00);
        send_cmd(8'd1);
        t0 = tx_cnt;
        c = 0;
        while (tx_cnt == t0 && c < 400) begin @(negedge CLK); c++; end
        chk("rst_mid_first_byte_timeout", 32'(c >= 400), 0);
        repeat (5) @(negedge CLK);
        @(posedge CLK); #3 Rst_n = 1'b0;
        #1;
        chk("amid_tx_en", bus.tx_en, 0);
        chk("amid_tx_data", bus.tx_data, 8'h00);
        chk("amid_busy", bus.busy, 0);
        chk("amid_overrun", bus.overrun, 0);
        chk("amid_mode", bus.mode, 3'd3);
        chk("amid_streaming", bus.streaming, 0);
        exp_q.delete();
        repeat (3) @(posedge CLK);
        #1 Rst_n = 1'b1;
        set_buses(16'h0000, 16'h0AB0);
        t0 = tx_cnt;
        repeat (300) @(negedge CLK);
        chk("post_rst_no_tx_en", tx_cnt, t0);
        push_pkt(1'b0, 8'hAB);
        send_cmd(8'd1);
        wait_sig(0, 1'b1, 9000, "post_rst_pkt_start", c);
        chk("post_rst_period_8192", 32'(c >= 7500), 1);
        send_cmd(8'd0);
        wait_sig(0, 1'b0, 600, "post_rst_pkt_end", c);
        chk("post_rst_pkt_complete", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/bt_stream_packetizer.md
Name: bt_stream_packetizer

Overview:
- Parametrised Bluetooth telemetry framer that replaces the fixed 8-slot, LOOP_TIME-decoded UART transmit scheme.
- Counts acquisition frames and snapshots NCH channels of raw or RMS data at a commanded period.
- Converts each channel to one byte according to the data mode and streams a framed packet to the UART transmitter with a ready/done handshake.
- Sits between the Intan capture/RMS stage and UART_rs232_tx; it also decodes command bytes from UART_rs232_rx_bis.

Parameters:
- NCH, 8, number of channels per packet (1..32).
- SAMPLE_W, 16, width of each raw and RMS word (>=16).
- CNT_W, 16, width of the frame-period counter (>=15).
- SYNC_BYTE, 8'hA5, first byte of every packet.

Ports:
- CLK  in  1  system clock (16 MHz).
- Rst_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  one-cycle pulse, once per complete acquisition frame.
- raw_bus  in  NCH*SAMPLE_W  raw samples; channel k at [k*SAMPLE_W +: SAMPLE_W].
- rms_bus  in  NCH*SAMPLE_W  RMS values, same packing as raw_bus.
- rx_valid  in  1  one-cycle pulse; rx_data holds a command byte.
- rx_data  in  8  command byte.
- tx_ready  in  1  UART transmitter idle.
- tx_done  in  1  one-cycle pulse when a byte has finished transmitting.
- tx_en  out  1  one-cycle start pulse to the UART.
- tx_data  out  8  byte to transmit; stable from tx_en until tx_done.
- busy  out  1  packet in progress.
- overrun  out  1  sticky flag: a period tick was dropped.
- mode  out  3  current data mode.
- streaming  out  1  streaming enabled.

Behaviour:

Reset values:
- tx_en=0, tx_data=8'h00, busy=0, overrun=0, mode=3'd3 (RMS_HIGH), streaming=0.
- period=8192, frame counter=0, FSM=IDLE.
- Reset is asynchronous. Asserting it mid-packet aborts the packet immediately; no further tx_en is issued.

Command decode (applied on the clock edge where rx_valid=1):
- 0: streaming=0.
- 1: streaming=1 and overrun cleared.
- 2/3/9/10: period = 8192 / 16384 / 512 / 256; frame counter cleared to 0.
- 4/5/6/7/8: mode = 0 RAW_LOW / 1 RAW_HIGH / 2 RMS_LOW / 3 RMS_HIGH / 4 DEBUG.
- Any other value: ignored.

Frame counter:
- Increments on sample_valid.
- When count==period-1 and sample_valid=1: tick, and count returns to 0.
- If a command and a tick land on the same cycle, the tick uses the pre-command registers. The period command then clears the counter.

Tick handling:
- tick, streaming=1, FSM IDLE: snapshot every channel's byte into shadow registers on that edge, using mode as it stood before the edge.
- tick, FSM not IDLE: packet dropped, overrun=1, in-flight packet unaffected.
- tick, streaming=0: no action.

Byte slicing for channel k (s=raw, r=rms):
- RAW_LOW = {s[SAMPLE_W-1], s[12:6]}.
- RAW_HIGH = {s[SAMPLE_W-1], s[10:4]}.
- RMS_LOW = r[13:6].
- RMS_HIGH = r[11:4].
- DEBUG = k[7:0].
- An unused mode encoding falls back to DEBUG.

FSM states: IDLE -> LOAD -> ISSUE -> WAIT -> (ISSUE | CSUM_ISSUE | IDLE).
- LOAD: one cycle; selects SYNC_BYTE and sets the byte index to 0.
- ISSUE: waits for tx_ready=1, then drives tx_en=1 for exactly one cycle with tx_data valid in the same cycle, and moves to WAIT.
- WAIT: holds tx_data until tx_done. Next comes the channel bytes 0..NCH-1 in order, then checksum (if enabled), then IDLE.
- busy=1 in every state except IDLE.
- Packet length is 1+NCH bytes, or 2+NCH with the checksum.

Timing and stability:
- Latency: tick at edge T gives the earliest tx_en for SYNC in the cycle after T+1, provided tx_ready=1.
- streaming=0 mid-packet: the current packet completes; no new packets start.
- Mode or period change mid-packet: no effect on the current packet.
- tx_done while in ISSUE or IDLE: ignored.

Optional Feature:
- Macro: PKT_CHECKSUM_EN.
- Defined: a trailing byte is appended, equal to the XOR of SYNC_BYTE and all NCH data bytes, sent through the same ISSUE/WAIT handshake.
- Undefined: no CSUM state; the packet ends after channel NCH-1 and the FSM returns to IDLE on that tx_done.

Test Plan:
- Reset, cmd 10, cmd 8, cmd 1, sample_valid every 32 cycles, UART model (tx_ready high, tx_done 20 cycles after tx_en) -> every 256th frame sends A5,00,01,..,07; with the checksum, A5 then 00..07 then byte A5.
- cmd 4, raw ch0=16'h8FC0 -> ch0 byte 8'hBF; cmd 7, rms ch0=16'h0AB0 -> 8'hAB.
- cmd 10, UART model stretches tx_done to 400 cycles per byte -> next tick sets overrun=1, in-flight packet completes intact; cmd 1 clears overrun.
- cmd 0 issued after 3rd byte of a packet -> remaining bytes sent, no further tx_en, streaming=0.
- tx_ready held low 50 cycles after LOAD -> no tx_en until tx_ready rises, then exactly one tx_en pulse.
- Rst_n asserted mid-packet, between tx_en and tx_done -> all outputs return to reset values asynchronously; after release, no tx_en until the next tick with streaming=1.
